serial_adder: RTL and testbench

Parametrised digit-serial adder: the multi-bit, clocked successor of the team's single-bit full adder cell. Computes s = a + b + c_in over WIDTH bits, DIGIT bits per clock, using a registered carry between digits. Operands enter and results leave through valid/ready handshakes. Used where area matters more than latency, such as accumulators and checksum paths.

---
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial adder computing s = a + b + c_in over WIDTH bits,
//               DIGIT bits per clock through a registered inter-digit carry.
//               Operands enter and results leave on valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    // Number of digit steps per operation and the counter width that spans them.
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    // Carry chain through the current digit; w_c[0] is the registered carry.
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_dsum;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_ovf_next;
    logic             w_last;

    assign w_c[0] = r_carry;
    assign w_last = (r_cnt == CW'(N - 1));

    // One full-adder cell per bit of the digit, rippling the carry upward.
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            assign w_dsum[i]  = r_a[i] ^ r_b[i] ^ w_c[i];
            assign w_c[i + 1] = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
    endgenerate

    // New digit enters the sum register at the MSB end; after N steps the
    // first digit computed has reached bit 0.
    generate
        if (N > 1) begin : g_sum_shift
            assign w_sum_next = {w_dsum, r_sum[WIDTH-1:DIGIT]};
        end else begin : g_sum_single
            assign w_sum_next = w_dsum;
        end
    endgenerate

    // During the last digit, w_c[DIGIT-1] is the carry into bit WIDTH-1 and
    // w_c[DIGIT] the carry out of it.
    generate
        if (SIGNED != 0) begin : g_ovf_signed
            assign w_ovf_next = w_c[DIGIT - 1] ^ w_c[DIGIT];
        end else begin : g_ovf_unsigned
            assign w_ovf_next = w_c[DIGIT];
        end
    endgenerate

    // Control FSM plus datapath registers; all handshake outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_carry  <= c_in;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_c[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        s         <= w_sum_next;
                        c_out     <= w_c[DIGIT];
                        ovf       <= w_ovf_next;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result held until the consumer takes it; no accept this cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder across several parameter
//               sets, checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk;
    logic rst_n;

    // 8-bit, DIGIT=1 pair (unsigned and signed) driven in lockstep.
    logic       iv8, or8, c8;
    logic [7:0] a8, b8;
    logic       ir8u, ov8u, co8u, ovf8u;
    logic [7:0] s8u;
    logic       ir8s, ov8s, co8s, ovf8s;
    logic [7:0] s8s;

    // 16-bit, DIGIT=4.
    logic        iv16, or16, c16;
    logic [15:0] a16, b16;
    logic        ir16, ov16, co16, ovf16;
    logic [15:0] s16;

    // 4-bit, DIGIT=2.
    logic       iv4, or4, c4;
    logic [3:0] a4, b4;
    logic       ir4, ov4, co4, ovf4;
    logic [3:0] s4;

    int n_pass  = 0;
    int n_total = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u8u (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8u), .a(a8), .b(b8),
        .c_in(c8), .out_valid(ov8u), .out_ready(or8), .s(s8u), .c_out(co8u), .ovf(ovf8u));

    serial_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) u8s (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8s), .a(a8), .b(b8),
        .c_in(c8), .out_valid(ov8s), .out_ready(or8), .s(s8s), .c_out(co8s), .ovf(ovf8s));

    serial_adder #(.WIDTH(16), .DIGIT(4), .SIGNED(0)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .c_in(c16), .out_valid(ov16), .out_ready(or16), .s(s16), .c_out(co16), .ovf(ovf16));

    serial_adder #(.WIDTH(4), .DIGIT(2), .SIGNED(0)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .c_in(c4), .out_valid(ov4), .out_ready(or4), .s(s4), .c_out(co4), .ovf(ovf4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operands.
    function automatic void model8(input logic [7:0] a, input logic [7:0] b, input logic c,
                                   output logic [7:0] s, output logic co,
                                   output logic ovf_u, output logic ovf_s);
        int t;
        int sa;
        int sb;
        int sv;
        t  = int'(a) + int'(b) + int'(c);
        s  = t[7:0];
        co = (t > 255);
        ovf_u = co;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sv = sa + sb + int'(c);
        ovf_s = (sv > 127) || (sv < -128);
    endfunction

    // Protocol monitor: handshake exclusivity and result stability under backpressure.
    logic       hold8;
    logic [9:0] snap8;
    initial hold8 = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            n_total++;
            if ((ov8u && ir8u) || (ov8s && ir8s) || (ov16 && ir16) || (ov4 && ir4))
                $display("FAIL valid_ready_exclusive out_valid/in_ready both high at %0t", $time);
            else
                n_pass++;
            if (hold8) begin
                n_total++;
                if ({s8u, co8u, ovf8u} !== snap8)
                    $display("FAIL hold_stable got=%h required=%h", {s8u, co8u, ovf8u}, snap8);
                else
                    n_pass++;
            end
        end
        hold8 = rst_n && ov8u && !or8;
        snap8 = {s8u, co8u, ovf8u};
    end

    // Offer operands to the 8-bit pair and return edges from accept to out_valid.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        int guard;
        guard = 0;
        a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
        while (!ir8u && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8u && lat < 50) begin @(posedge clk); #1; lat++; end
        n_total++;
        if (!ov8u) $display("FAIL op8_timeout out_valid=%b required=1", ov8u);
        else n_pass++;
    endtask

    task automatic finish8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({ir8u, ov8u, s8u, co8u, ovf8u} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_u8u got=%b", {ir8u, ov8u, s8u, co8u, ovf8u});
        else n_pass++;
        n_total++;
        if ({ir8s, ov8s, s8s, co8s, ovf8s} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_u8s got=%b", {ir8s, ov8s, s8s, co8s, ovf8s});
        else n_pass++;
        n_total++;
        if ({ir16, ov16, s16, co16, ovf16} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_u16 got=%b", {ir16, ov16, s16, co16, ovf16});
        else n_pass++;
        n_total++;
        if ({ir4, ov4, s4, co4, ovf4} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_u4 got=%b", {ir4, ov4, s4, co4, ovf4});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic();
        int lat;
        op8(8'hFF, 8'h01, 1'b0, lat);
        n_total++;
        if (lat !== 8) $display("FAIL latency8 got=%0d required=8", lat);
        else n_pass++;
        n_total++;
        if ({co8u, s8u, ovf8u} !== {1'b1, 8'h00, 1'b1})
            $display("FAIL unsigned_ff_01 got=%h required=%h", {co8u, s8u, ovf8u}, {1'b1, 8'h00, 1'b1});
        else n_pass++;
        finish8();
    endtask

    task automatic test_signed_ovf();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [9:0] exp_v [3];
        int lat;
        ta[0] = 8'h7F; tb[0] = 8'h01; exp_v[0] = {1'b0, 8'h80, 1'b1};
        ta[1] = 8'h80; tb[1] = 8'hFF; exp_v[1] = {1'b1, 8'h7F, 1'b1};
        ta[2] = 8'hFF; tb[2] = 8'h01; exp_v[2] = {1'b1, 8'h00, 1'b0};
        for (int i = 0; i < 3; i++) begin
            op8(ta[i], tb[i], 1'b0, lat);
            n_total++;
            if ({co8s, s8s, ovf8s} !== exp_v[i])
                $display("FAIL signed_case%0d got=%h required=%h", i, {co8s, s8s, ovf8s}, exp_v[i]);
            else n_pass++;
            finish8();
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        int cnt;
        or8 = 1'b1;
        a8 = 8'h5A; b8 = 8'hA5; c8 = 1'b0; iv8 = 1'b1;
        guard = 0;
        while (!ov8u && guard < 40) begin @(posedge clk); #1; guard++; end
        n_total++;
        if ({ov8u, co8u, s8u} !== {1'b1, 1'b0, 8'hFF})
            $display("FAIL b2b_first got=%h required=%h", {ov8u, co8u, s8u}, {1'b1, 1'b0, 8'hFF});
        else n_pass++;
        a8 = 8'hC3; b8 = 8'h3C; c8 = 1'b1;
        cnt = 0;
        while ((!ov8u || cnt < 2) && cnt < 40) begin @(posedge clk); #1; cnt++; end
        n_total++;
        if (cnt !== 10) $display("FAIL b2b_interval got=%0d required=10", cnt);
        else n_pass++;
        n_total++;
        if ({ov8u, co8u, s8u} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL b2b_second got=%h required=%h", {ov8u, co8u, s8u}, {1'b1, 1'b1, 8'h00});
        else n_pass++;
        or8 = 1'b0; iv8 = 1'b0;
        finish8();
    endtask

    task automatic test_backpressure();
        int lat;
        int guard;
        op8(8'h11, 8'h22, 1'b0, lat);
        a8 = 8'h33; b8 = 8'h44; c8 = 1'b0; iv8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_total++;
            if ({ov8u, ir8u, co8u, s8u, ovf8u} !== {1'b1, 1'b0, 1'b0, 8'h33, 1'b0})
                $display("FAIL bp_hold%0d got=%h required=%h", k,
                         {ov8u, ir8u, co8u, s8u, ovf8u}, {1'b1, 1'b0, 1'b0, 8'h33, 1'b0});
            else n_pass++;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        n_total++;
        if ({ir8u, ov8u} !== 2'b10) $display("FAIL bp_release got=%b required=10", {ir8u, ov8u});
        else n_pass++;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n_total++;
        if (ir8u !== 1'b0) $display("FAIL bp_accept in_ready=%b required=0", ir8u);
        else n_pass++;
        guard = 0;
        while (!ov8u && guard < 40) begin @(posedge clk); #1; guard++; end
        n_total++;
        if ({ov8u, co8u, s8u} !== {1'b1, 1'b0, 8'h77})
            $display("FAIL bp_result got=%h required=%h", {ov8u, co8u, s8u}, {1'b1, 1'b0, 8'h77});
        else n_pass++;
        finish8();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({ir8u, ov8u, s8u, co8u, ovf8u} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL midrun_reset got=%b required=%b", {ir8u, ov8u, s8u, co8u, ovf8u},
                     {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        op8(8'h12, 8'h34, 1'b1, lat);
        n_total++;
        if ({lat[3:0], co8u, s8u} !== {4'd8, 1'b0, 8'h47})
            $display("FAIL after_reset got=%h required=%h", {lat[3:0], co8u, s8u}, {4'd8, 1'b0, 8'h47});
        else n_pass++;
        finish8();
    endtask

    task automatic test_wide_digit();
        int lat;
        a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_total++;
        if (lat !== 4) $display("FAIL latency16 got=%0d required=4", lat);
        else n_pass++;
        n_total++;
        if ({ov16, co16, s16, ovf16} !== {1'b1, 1'b1, 16'h0000, 1'b1})
            $display("FAIL wide_result got=%h required=%h", {ov16, co16, s16, ovf16},
                     {1'b1, 1'b1, 16'h0000, 1'b1});
        else n_pass++;
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    task automatic test_exhaustive();
        int guard;
        int t;
        logic [4:0] e;
        or4 = 1'b1; iv4 = 1'b1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai); b4 = 4'(bi); c4 = ci[0];
                    guard = 0;
                    while (!ir4 && guard < 20) begin @(posedge clk); #1; guard++; end
                    @(posedge clk); #1;
                    guard = 0;
                    while (!ov4 && guard < 20) begin @(posedge clk); #1; guard++; end
                    t = ai + bi + ci;
                    e = t[4:0];
                    n_total++;
                    if ({ov4, co4, s4} !== {1'b1, e})
                        $display("FAIL exh a=%h b=%h c=%0d got=%h required=%h", ai, bi, ci,
                                 {ov4, co4, s4}, {1'b1, e});
                    else n_pass++;
                end
            end
        end
        @(posedge clk); #1;
        or4 = 1'b0; iv4 = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, es;
        logic       rc, eco, eou, eos;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model8(ra, rb, rc, es, eco, eou, eos);
            op8(ra, rb, rc, lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            n_total++;
            if ({co8u, s8u, ovf8u} !== {eco, es, eou})
                $display("FAIL rand_u a=%h b=%h c=%b got=%h required=%h", ra, rb, rc,
                         {co8u, s8u, ovf8u}, {eco, es, eou});
            else n_pass++;
            n_total++;
            if ({co8s, s8s, ovf8s} !== {eco, es, eos})
                $display("FAIL rand_s a=%h b=%h c=%b got=%h required=%h", ra, rb, rc,
                         {co8s, s8s, ovf8s}, {eco, es, eos});
            else n_pass++;
            finish8();
        end
    endtask

    initial begin
        iv8 = 1'b0; or8 = 1'b0; c8 = 1'b0; a8 = '0; b8 = '0;
        iv16 = 1'b0; or16 = 1'b0; c16 = 1'b0; a16 = '0; b16 = '0;
        iv4 = 1'b0; or4 = 1'b0; c4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_unsigned_basic();
        test_signed_ovf();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_wide_digit();
        test_exhaustive();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
